fall_tick_gen: RTL and testbench
================================

// Module: fall_tick_gen
// PURPOSE
//  Parametrised gravity tick generator: level -> fall period (clock cycles)
//  plus free-running counter emitting one-cycle drop pulses. Supersedes the
//  fixed level->speed lookup; sits between level/score logic and piece mover.
//  Adds clamping, pause, restart and mid-count level-change handling.
// PARAMETERS
//  LVL_W        4         width of level input
//  CNT_W        32        width of period/counter
//  BASE_PERIOD  11000000  period at level 0 (cycles)
//  STEP         400000    period decrement per level
//  MIN_PERIOD   2000000   floor on computed period (>=2)
//  MAX_LVL      14        levels above this are treated as MAX_LVL
//  SOFT_SHIFT   3         soft-drop divides period by 2**SOFT_SHIFT
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  level      in   LVL_W  current level
//  enable     in   1      game running
//  pause      in   1      hold counter, suppress ticks
//  restart    in   1      zero counter (new piece spawned)
//  soft_drop  in   1      fast fall (only with FALL_TICK_SOFTDROP_EN)
//  tick       out  1      one-cycle drop pulse
//  period     out  CNT_W  registered effective period in use
//  running    out  1      high in RUN state
// BEHAVIOUR
//  Reset (async, rst_n=0): tick=0, running=0, cnt=0, period=BASE_PERIOD, IDLE.
//  Period calc: L=min(level,MAX_LVL); raw = L*STEP;
//   period_q = (raw >= BASE_PERIOD-MIN_PERIOD) ? MIN_PERIOD : BASE_PERIOD-raw.
//   No subtraction underflow permitted. Registered: 1-cycle latency from level.
//  Effective P = period_q, or with soft drop active max(period_q>>SOFT_SHIFT,1).
//  FSM: IDLE -(enable)-> RUN; RUN -(pause)-> PAUSED; PAUSED -(!pause)-> RUN;
//   any state -(!enable)-> IDLE (cnt<=0). enable has priority over pause.
//  RUN: cnt increments each cycle; when cnt >= P-1: tick<=1 next cycle, cnt<=0.
//   First tick exactly P cycles after the edge entering RUN; then every P.
//  tick is registered; never high two consecutive cycles when P>=2.
//  PAUSED: cnt frozen, tick=0; resume continues from frozen cnt.
//  restart (any state): cnt<=0, no tick that cycle; priority over terminal count.
//  Level change mid-count: cnt not reset; if cnt already >= new P-1, tick is
//   issued on next cycle (no wrap through 2**CNT_W).
//  running=1 only in RUN. period output updates even in IDLE/PAUSED.
// CONFIGURATION
//  FALL_TICK_SOFTDROP_EN defined: soft_drop port exists; while high and RUN,
//   P = max(period_q>>SOFT_SHIFT,1); on assert, if cnt>=new P-1, tick next cycle.
//  Undefined: no soft_drop port; P = period_q always.
// TESTING (BASE=20, STEP=2, MIN=6, MAX_LVL=14, SOFT_SHIFT=2, CNT_W=8)
//  level=0, enable=1 -> period=20, ticks every 20 cycles, 1 cycle wide.
//  level=5 -> period=10; level=7 -> 6; level=14 -> 6; level=15 -> 6 (clamp).
//  RUN level 0, at cnt=15 set level=5 -> tick next cycle, then every 10.
//  pause 7 cycles at cnt=8 -> no tick, next tick 12 cycles after resume.
//  restart at cnt=19 -> no tick, next tick 20 cycles later; rst_n low mid-run
//   -> tick=0, running=0, period=20 immediately (async).
//  SOFTDROP_EN, level 0, soft_drop=1 -> ticks every 5; release -> every 20.

Source files
------------

// File: rtl/fall_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fall_tick_gen
//  Purpose  : Gravity tick generator. Maps the current level to a fall period
//             in clock cycles and runs a free-running counter that emits a
//             one-cycle drop pulse every period. Supports pause, restart and
//             level changes in the middle of a count.
//  Options  : FALL_TICK_SOFTDROP_EN - when defined, adds the soft_drop input,
//             which divides the period by 2**SOFT_SHIFT while running.
//  Revision : 1.0 - initial release
// ============================================================================
module fall_tick_gen #(
  parameter int LVL_W       = 4,
  parameter int CNT_W       = 32,
  parameter int BASE_PERIOD = 11000000,
  parameter int STEP        = 400000,
  parameter int MIN_PERIOD  = 2000000,
  parameter int MAX_LVL     = 14,
  parameter int SOFT_SHIFT  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] level,
  input  logic             enable,
  input  logic             pause,
  input  logic             restart,
`ifdef FALL_TICK_SOFTDROP_EN
  input  logic             soft_drop,
`endif
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             running
);

  // Product L*STEP gets extra headroom so it can never wrap before the clamp.
  localparam int               c_raw_w   = CNT_W + LVL_W;
  localparam logic [LVL_W-1:0] c_max_lvl = LVL_W'(MAX_LVL);
  localparam logic [c_raw_w-1:0] c_span  = c_raw_w'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [c_raw_w-1:0] c_step  = c_raw_w'(STEP);
  localparam logic [CNT_W-1:0] c_base    = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0] c_min     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [LVL_W-1:0]   w_lvl;
  logic [c_raw_w-1:0] w_raw;
  logic [CNT_W-1:0]   w_base_next;
  logic [CNT_W-1:0]   w_period_next;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tick;
  logic               w_count_en;
  logic               w_term;

  // Clamp the level and derive the base period; the comparison against the
  // span is done before subtracting so the result can never underflow.
  always_comb begin
    w_lvl       = (level > c_max_lvl) ? c_max_lvl : level;
    w_raw       = c_raw_w'(w_lvl) * c_step;
    w_base_next = (w_raw >= c_span) ? c_min : (c_base - w_raw[CNT_W-1:0]);
  end

`ifdef FALL_TICK_SOFTDROP_EN
  logic             w_soft_active;
  logic [CNT_W-1:0] w_soft_period;

  // Soft drop shortens the period only while actually running; the period is
  // never allowed to reach zero.
  always_comb begin
    w_soft_active = soft_drop && (r_state == ST_RUN);
    w_soft_period = w_base_next >> SOFT_SHIFT;
    if (w_soft_period == '0) begin
      w_soft_period = c_one;
    end
    w_period_next = w_soft_active ? w_soft_period : w_base_next;
  end
`else
  // Without soft drop the effective period is the level-derived period.
  always_comb begin
    w_period_next = w_base_next;
  end
`endif

  // Effective period register; tracks level even while idle or paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= c_base;
    end else begin
      r_period <= w_period_next;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: dropping enable wins over everything else.
  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_next = ST_RUN;
        ST_RUN:    if (pause)  w_state_next = ST_PAUSED;
        ST_PAUSED: if (!pause) w_state_next = ST_RUN;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // Counting happens only in RUN with no pause request. The terminal test is
  // ">=" so a period that shrinks below the current count fires immediately
  // instead of wrapping the counter.
  always_comb begin
    w_count_en = (r_state == ST_RUN) && enable && !pause;
    w_term     = (r_cnt >= (r_period - c_one));
  end

  // Counter and registered tick; restart and disable clear the count and
  // suppress any tick that would otherwise have fired this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (restart || !enable) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_count_en) begin
      if (w_term) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + c_one;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick    = r_tick;
  assign period  = r_period;
  assign running = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_fall_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fall_tick_gen
//  Purpose  : Self-checking bench for fall_tick_gen with small parameters
//             (BASE=20, STEP=2, MIN=6, MAX_LVL=14, SOFT_SHIFT=2, CNT_W=8).
//             Expected tick cycles are queued by the stimulus and consumed by
//             a monitor that watches the tick output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fall_tick_gen;

  localparam int LVL_W = 4;
  localparam int CNT_W = 8;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic [LVL_W-1:0] level   = '0;
  logic             enable  = 1'b0;
  logic             pause   = 1'b0;
  logic             restart = 1'b0;
`ifdef FALL_TICK_SOFTDROP_EN
  logic             soft_drop = 1'b0;
`endif
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             running;

  int cyc     = 0;
  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];
  int mon_exp;

  fall_tick_gen #(
    .LVL_W      (LVL_W),
    .CNT_W      (CNT_W),
    .BASE_PERIOD(20),
    .STEP       (2),
    .MIN_PERIOD (6),
    .MAX_LVL    (14),
    .SOFT_SHIFT (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .level    (level),
    .enable   (enable),
    .pause    (pause),
    .restart  (restart),
`ifdef FALL_TICK_SOFTDROP_EN
    .soft_drop(soft_drop),
`endif
    .tick     (tick),
    .period   (period),
    .running  (running)
  );

  // Clock and edge counter: after the k-th rising edge, cyc == k.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Advance n rising edges, then step just past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every tick must match the oldest queued expected cycle; an
  // expected cycle that passes without a tick is reported as missing.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_total++;
        $display("FAIL tick_missing: no tick, expected at cycle %0d (now %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (tick) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL tick_unexpected: tick at cycle %0d, expected none", cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          n_total++;
          if (mon_exp == cyc) begin
            n_pass++;
          end else begin
            $display("FAIL tick_cycle: tick at cycle %0d, expected cycle %0d", cyc, mon_exp);
          end
        end
      end
    end
  end

  initial begin : stim
    int k;
    int lv_tab[6];
    int pd_tab[6];
    lv_tab = '{5, 7, 14, 15, 3, 0};
    pd_tab = '{10, 6, 6, 6, 14, 20};

    // Reset values.
    step(3);
    chk("reset_tick", int'(tick), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_period", int'(period), 20);
    rst_n = 1'b1;
    step(1);

    // Period is registered: no change before the next edge.
    level = 4'd5;
    #2;
    chk("period_latency", int'(period), 20);
    step(1);

    // Level to period mapping including clamp above MAX_LVL.
    for (int i = 0; i < 6; i++) begin
      level = lv_tab[i][LVL_W-1:0];
      step(1);
      chk($sformatf("period_lvl%0d", lv_tab[i]), int'(period), pd_tab[i]);
    end
    chk("idle_running", int'(running), 0);

    // Level 0 run: ticks every 20 cycles, first 20 cycles after entering RUN.
    k = cyc;
    enable = 1'b1;
    exp_q.push_back(k + 21);
    exp_q.push_back(k + 41);
    exp_q.push_back(k + 61);
    step(1);
    chk("run_running", int'(running), 1);
    step(61);
    enable = 1'b0;
    step(1);
    chk("disable_running", int'(running), 0);
    step(2);

    // Level change at cnt=15: new period 10 already exceeded, tick at once.
    k = cyc;
    enable = 1'b1;
    exp_q.push_back(k + 18);
    exp_q.push_back(k + 28);
    exp_q.push_back(k + 38);
    step(16);
    level = 4'd5;
    step(23);
    enable = 1'b0;
    level  = 4'd0;
    step(2);

    // Pause for 7 cycles at cnt=8; count resumes from 8.
    k = cyc;
    enable = 1'b1;
    exp_q.push_back(k + 29);
    exp_q.push_back(k + 49);
    step(9);
    pause = 1'b1;
    step(3);
    chk("paused_running", int'(running), 0);
    step(4);
    pause = 1'b0;
    step(34);
    enable = 1'b0;
    step(2);

    // Restart at terminal count (level 5, period 10), then async reset.
    level = 4'd5;
    step(1);
    k = cyc;
    enable = 1'b1;
    exp_q.push_back(k + 21);
    exp_q.push_back(k + 31);
    step(10);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(24);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tick", int'(tick), 0);
    chk("async_running", int'(running), 0);
    chk("async_period", int'(period), 20);
    enable = 1'b0;
    level  = 4'd0;
    step(1);
    rst_n = 1'b1;
    step(2);

`ifdef FALL_TICK_SOFTDROP_EN
    // Soft drop at level 0: period 5 while held, back to 20 after release.
    soft_drop = 1'b1;
    k = cyc;
    enable = 1'b1;
    exp_q.push_back(k + 6);
    exp_q.push_back(k + 11);
    exp_q.push_back(k + 16);
    exp_q.push_back(k + 36);
    step(3);
    chk("soft_period", int'(period), 5);
    step(14);
    soft_drop = 1'b0;
    step(20);
    enable = 1'b0;
    step(2);
`endif

    step(5);
    chk("tick_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
